// File: rtl/mips_defs_pkg.sv
// Shared MIPS decode constants and the 2-bit Tuse/Tnew encodings used by the
// hazard logic.
package mips_defs;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   localparam logic [4:0] REG_RA = 5'd31;

   // TUSE_NONE sits above every Tnew so an unused operand never compares as a hazard.
   typedef logic [1:0] tuse_t;
   localparam tuse_t TUSE_0    = 2'd0;
   localparam tuse_t TUSE_1    = 2'd1;
   localparam tuse_t TUSE_2    = 2'd2;
   localparam tuse_t TUSE_NONE = 2'd3;

   typedef logic [1:0] tnew_t;
   localparam tnew_t TNEW_0 = 2'd0;
   localparam tnew_t TNEW_1 = 2'd1;
   localparam tnew_t TNEW_2 = 2'd2;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

endpackage

// File: rtl/instr_class.sv
// Decodes one instruction word into the register/timing attributes the
// stall controller needs; tnew is reported as seen from the E stage.
module instr_class
   import mips_defs::*;
(
   input  logic [31:0] ir,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  dest,
   output tuse_t       tuse_rs,
   output tuse_t       tuse_rt,
   output tnew_t       tnew,
   output logic        is_md,
   output logic        is_md_start,
   output logic        is_div
);

   logic [5:0] op;
   logic [5:0] fn;
   logic [4:0] rd;
   logic       unused_shamt;

   assign op           = ir[31:26];
   assign fn           = ir[5:0];
   assign rs           = ir[25:21];
   assign rt           = ir[20:16];
   assign rd           = ir[15:11];
   assign unused_shamt = ^ir[10:6];

   always_comb begin
      dest        = 5'd0;
      tuse_rs     = TUSE_NONE;
      tuse_rt     = TUSE_NONE;
      tnew        = TNEW_0;
      is_md       = 1'b0;
      is_md_start = 1'b0;
      is_div      = 1'b0;
      case (op)
         OP_RTYPE: begin
            case (fn)
               FN_ADDU, FN_SUBU: begin
                  dest    = rd;
                  tuse_rs = TUSE_1;
                  tuse_rt = TUSE_1;
                  tnew    = TNEW_1;
               end
               FN_MFHI, FN_MFLO: begin
                  dest  = rd;
                  tnew  = TNEW_1;
                  is_md = 1'b1;
               end
               FN_MTHI, FN_MTLO: begin
                  tuse_rs = TUSE_1;
                  is_md   = 1'b1;
               end
               FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                  tuse_rs     = TUSE_1;
                  tuse_rt     = TUSE_1;
                  is_md       = 1'b1;
                  is_md_start = 1'b1;
                  is_div      = (fn == FN_DIV) || (fn == FN_DIVU);
               end
               FN_JR: tuse_rs = TUSE_0;
               default: ;
            endcase
         end
         OP_ORI: begin
            dest    = rt;
            tuse_rs = TUSE_1;
            tnew    = TNEW_1;
         end
         OP_LUI: begin
            dest = rt;
            tnew = TNEW_1;
         end
         OP_LW: begin
            dest    = rt;
            tuse_rs = TUSE_1;
            tnew    = TNEW_2;
         end
         OP_SW: begin
            tuse_rs = TUSE_1;
            tuse_rt = TUSE_2;
         end
         OP_BEQ: begin
            tuse_rs = TUSE_0;
            tuse_rt = TUSE_0;
         end
         OP_JAL: begin
            dest = REG_RA;
            tnew = TNEW_0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/bubble controller: Tuse/Tnew data hazards against E and M,
// plus the busy-counter FSM that sequences the multicycle HI/LO unit.
module hazard_stall_ctrl
   import mips_defs::*;
#(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10,
   parameter int CNT_W    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IR_D,
   input  logic [31:0] IR_E,
   input  logic [31:0] IR_M,
   output logic        stall,
   output logic        en_pc,
   output logic        en_FD,
   output logic        clr_DE,
   output logic        md_start,
   output logic        md_busy
);

   logic [4:0] d_rs, d_rt, e_rs, e_rt, m_rs, m_rt;
   logic [4:0] d_dest, e_dest, m_dest;
   tuse_t      d_tuse_rs, d_tuse_rt, e_tuse_rs, e_tuse_rt, m_tuse_rs, m_tuse_rt;
   tnew_t      d_tnew, e_tnew, m_tnew_raw, m_tnew;
   logic       d_is_md, e_is_md, m_is_md;
   logic       d_is_start, e_is_start, m_is_start;
   logic       d_is_div, e_is_div, m_is_div;
   logic       unused_decode;

   instr_class u_class_d (
      .ir(IR_D), .rs(d_rs), .rt(d_rt), .dest(d_dest),
      .tuse_rs(d_tuse_rs), .tuse_rt(d_tuse_rt), .tnew(d_tnew),
      .is_md(d_is_md), .is_md_start(d_is_start), .is_div(d_is_div)
   );

   instr_class u_class_e (
      .ir(IR_E), .rs(e_rs), .rt(e_rt), .dest(e_dest),
      .tuse_rs(e_tuse_rs), .tuse_rt(e_tuse_rt), .tnew(e_tnew),
      .is_md(e_is_md), .is_md_start(e_is_start), .is_div(e_is_div)
   );

   instr_class u_class_m (
      .ir(IR_M), .rs(m_rs), .rt(m_rt), .dest(m_dest),
      .tuse_rs(m_tuse_rs), .tuse_rt(m_tuse_rt), .tnew(m_tnew_raw),
      .is_md(m_is_md), .is_md_start(m_is_start), .is_div(m_is_div)
   );

   assign unused_decode = ^{d_dest, d_tnew, d_is_start, d_is_div,
                            e_rs, e_rt, e_tuse_rs, e_tuse_rt, e_is_md,
                            m_rs, m_rt, m_tuse_rs, m_tuse_rt, m_is_md,
                            m_is_start, m_is_div};

   // One stage later, every producer is one cycle closer to having its result.
   assign m_tnew = (m_tnew_raw == TNEW_0) ? TNEW_0 : m_tnew_raw - 2'd1;

   function automatic logic src_hazard(input logic [4:0] src, input tuse_t tuse,
                                       input logic [4:0] dst, input tnew_t tnew);
      return (src != 5'd0) && (src == dst) && (tuse < tnew);
   endfunction

   logic data_stall;
   logic md_stall;

   assign data_stall = src_hazard(d_rs, d_tuse_rs, e_dest, e_tnew) |
                       src_hazard(d_rt, d_tuse_rt, e_dest, e_tnew) |
                       src_hazard(d_rs, d_tuse_rs, m_dest, m_tnew) |
                       src_hazard(d_rt, d_tuse_rt, m_dest, m_tnew);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign md_start = e_is_start && (state_q == MD_IDLE);
   assign md_busy  = (state_q == MD_BUSY);
   assign md_stall = d_is_md && (md_start || md_busy);

   assign stall  = data_stall | md_stall;
   assign en_pc  = ~stall;
   assign en_FD  = ~stall;
   assign clr_DE = stall;

   // A start seen while BUSY is ignored; D-stage md_stall keeps that from happening.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         MD_IDLE: begin
            if (md_start) begin
               state_d = MD_BUSY;
               cnt_d   = e_is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
            end
         end
         MD_BUSY: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = MD_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = MD_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-program bench: a small pipeline driven by a spec-level hazard model,
// checked every cycle, with hand-computed stall-cycle totals per program.
module tb_hazard_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] ir_d, ir_e, ir_m;
   logic        stall, en_pc, en_FD, clr_DE, md_start, md_busy;

   int vectors    = 0;
   int miscompares = 0;
   int busy       = 0;
   int dut_stalls = 0;
   int mod_stalls = 0;
   bit check_en   = 1'b0;
   logic [31:0] prog[$];

   always #5 clk = ~clk;

   hazard_stall_ctrl dut (
      .clk(clk), .reset(rst_n),
      .IR_D(ir_d), .IR_E(ir_e), .IR_M(ir_m),
      .stall(stall), .en_pc(en_pc), .en_FD(en_FD), .clr_DE(clr_DE),
      .md_start(md_start), .md_busy(md_busy)
   );

   function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'd0, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Spec-level classification: mnemonic lists mapped to numbers.
   function automatic bit is_r(input logic [31:0] ir, input int fn);
      return (ir[31:26] == 6'h00) && (int'(ir[5:0]) == fn);
   endfunction

   function automatic bit is_op(input logic [31:0] ir, input int op);
      return int'(ir[31:26]) == op;
   endfunction

   function automatic bit md_begin(input logic [31:0] ir);
      return is_r(ir, 'h18) || is_r(ir, 'h19) || is_r(ir, 'h1A) || is_r(ir, 'h1B);
   endfunction

   function automatic bit md_family(input logic [31:0] ir);
      return md_begin(ir) || is_r(ir, 'h10) || is_r(ir, 'h11) ||
             is_r(ir, 'h12) || is_r(ir, 'h13);
   endfunction

   function automatic int dest_of(input logic [31:0] ir);
      if (is_r(ir, 'h21) || is_r(ir, 'h23) || is_r(ir, 'h10) || is_r(ir, 'h12))
         return int'(ir[15:11]);
      if (is_op(ir, 'h0D) || is_op(ir, 'h0F) || is_op(ir, 'h23)) return int'(ir[20:16]);
      if (is_op(ir, 'h03)) return 31;
      return 0;
   endfunction

   function automatic int tnew_in_e(input logic [31:0] ir);
      if (is_op(ir, 'h23)) return 2;
      if (is_r(ir, 'h21) || is_r(ir, 'h23) || is_r(ir, 'h10) || is_r(ir, 'h12) ||
          is_op(ir, 'h0D) || is_op(ir, 'h0F)) return 1;
      return 0;
   endfunction

   function automatic int tnew_in_m(input logic [31:0] ir);
      return is_op(ir, 'h23) ? 1 : 0;
   endfunction

   // 99 marks an operand the instruction does not read.
   function automatic int use_rs(input logic [31:0] ir);
      if (is_op(ir, 'h04) || is_r(ir, 'h08)) return 0;
      if (is_r(ir, 'h21) || is_r(ir, 'h23) || is_op(ir, 'h0D) || is_op(ir, 'h23) ||
          is_op(ir, 'h2B) || md_begin(ir) || is_r(ir, 'h11) || is_r(ir, 'h13)) return 1;
      return 99;
   endfunction

   function automatic int use_rt(input logic [31:0] ir);
      if (is_op(ir, 'h04)) return 0;
      if (is_r(ir, 'h21) || is_r(ir, 'h23) || md_begin(ir)) return 1;
      if (is_op(ir, 'h2B)) return 2;
      return 99;
   endfunction

   function automatic bit exp_start();
      return md_begin(ir_e) && (busy == 0);
   endfunction

   function automatic bit exp_stall();
      int srcs[2];
      int uses[2];
      int dsts[2];
      int tns[2];
      bit hz = 1'b0;
      srcs[0] = int'(ir_d[25:21]); uses[0] = use_rs(ir_d);
      srcs[1] = int'(ir_d[20:16]); uses[1] = use_rt(ir_d);
      dsts[0] = dest_of(ir_e);     tns[0]  = tnew_in_e(ir_e);
      dsts[1] = dest_of(ir_m);     tns[1]  = tnew_in_m(ir_m);
      for (int x = 0; x < 2; x++)
         for (int s = 0; s < 2; s++)
            if (uses[s] != 99 && srcs[s] != 0 && srcs[s] == dsts[x] && uses[s] < tns[x])
               hz = 1'b1;
      return hz || (md_family(ir_d) && (exp_start() || busy > 0));
   endfunction

   always @(negedge clk) begin
      if (check_en) begin
         logic [5:0] got, want;
         bit s;
         s    = exp_stall();
         got  = {stall, en_pc, en_FD, clr_DE, md_start, md_busy};
         want = {s, ~s, ~s, s, exp_start(), busy > 0};
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL cycle_outputs D=%h E=%h M=%h got=%b want=%b",
                     ir_d, ir_e, ir_m, got, want);
         end
         if (stall === 1'b1) dut_stalls++;
      end
   end

   task automatic step();
      bit s, go;
      s  = exp_stall();
      go = exp_start();
      @(posedge clk);
      #1;
      if (busy > 0) busy--;
      else if (go) busy = md_begin(ir_e) && (is_r(ir_e, 'h1A) || is_r(ir_e, 'h1B)) ? 10 : 5;
      if (s) mod_stalls++;
      ir_m = ir_e;
      if (s) begin
         ir_e = 32'd0;
      end else begin
         ir_e = ir_d;
         ir_d = (prog.size() > 0) ? prog.pop_front() : 32'd0;
      end
   endtask

   task automatic check_lit(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic run_prog(input string name, input logic [31:0] a, input logic [31:0] b,
                           input int want_stalls);
      prog.delete();
      prog.push_back(a);
      prog.push_back(b);
      dut_stalls = 0;
      mod_stalls = 0;
      repeat (20) step();
      check_lit({name, "_dut_stalls"}, dut_stalls, want_stalls);
      check_lit({name, "_model_stalls"}, mod_stalls, want_stalls);
   endtask

   initial begin
      int guard;
      rst_n = 1'b0;
      ir_d = '0; ir_e = '0; ir_m = '0;
      #3;
      check_lit("reset_outputs", int'({stall, en_pc, en_FD, clr_DE, md_start, md_busy}),
                int'(6'b011000));
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_en = 1'b1;

      run_prog("lw_addu",  i_ins(6'h23, 0, 1, 0), r_ins(1, 3, 2, 6'h21), 1);
      run_prog("addu_beq", r_ins(1, 1, 4, 6'h21), i_ins(6'h04, 4, 0, 1), 1);
      run_prog("lw_beq",   i_ins(6'h23, 0, 4, 0), i_ins(6'h04, 4, 0, 1), 2);
      run_prog("lw_sw_rt", i_ins(6'h23, 0, 5, 0), i_ins(6'h2B, 6, 5, 0), 0);
      run_prog("lw_sw_rs", i_ins(6'h23, 0, 5, 0), i_ins(6'h2B, 5, 6, 0), 1);
      run_prog("ori_addu", i_ins(6'h0D, 0, 7, 5), r_ins(7, 7, 8, 6'h21), 0);
      run_prog("mult_mflo", r_ins(1, 2, 0, 6'h18), r_ins(0, 0, 3, 6'h12), 6);
      run_prog("div_mflo",  r_ins(1, 2, 0, 6'h1A), r_ins(0, 0, 3, 6'h12), 11);
      run_prog("lw0_addu", i_ins(6'h23, 0, 0, 0), r_ins(0, 0, 2, 6'h21), 0);
      run_prog("jal_jr",   {6'h03, 26'd4},        r_ins(31, 0, 0, 6'h08), 0);

      // Reset in the middle of a divide: busy must drop without a clock edge.
      prog.delete();
      prog.push_back(r_ins(1, 2, 0, 6'h1A));
      prog.push_back(r_ins(0, 0, 3, 6'h12));
      guard = 0;
      while (busy != 7 && guard < 30) begin
         step();
         guard++;
      end
      check_lit("reach_busy_cycle4", busy, 7);
      check_lit("busy_before_reset", int'(md_busy), 1);
      check_en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_lit("busy_async_clear", int'(md_busy), 0);
      busy = 0;
      prog.delete();
      ir_d = '0; ir_e = '0; ir_m = '0;
      #1;
      check_lit("outputs_in_reset", int'({stall, en_pc, en_FD, clr_DE, md_start, md_busy}),
                int'(6'b011000));
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_lit("idle_after_release", int'(md_busy), 0);
      check_en = 1'b1;
      run_prog("mult_after_reset", r_ins(1, 2, 0, 6'h19), r_ins(0, 0, 3, 6'h10), 6);

      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
